// File: rtl/id_sb_pkg.sv
// Shared definitions for the ID-stage scoreboard: NOP encoding, width helpers,
// operand-slice macro and register-file select.
`ifndef ID_SB_PKG_SV
`define ID_SB_PKG_SV

`define ID_SB_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package id_sb_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RF_INT = 1'b0, RF_FP = 1'b1} rf_sel_e;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

`endif

// File: rtl/sb_table.sv
// Pending-writer counters for one register file: hazard lookups for the source
// and destination operands, release decode and a sticky underflow flag.
module sb_table
  import id_sb_pkg::*;
#(
  parameter int      NUM_REGS = 32,
  parameter int      NUM_SRC  = 3,
  parameter int      NUM_REL  = 2,
  parameter int      CNT_W    = 2,
  parameter int      AW       = addr_w(NUM_REGS),
  parameter rf_sel_e FILE     = RF_INT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC*AW-1:0]  src_addr,
  input  logic [AW-1:0]          dst_addr,
  input  logic                   inc,
  input  logic [NUM_REL-1:0]     rel_hit,
  input  logic [NUM_REL*AW-1:0]  rel_addr,
  output logic [NUM_SRC-1:0]     src_busy,
  output logic [NUM_SRC-1:0]     src_one,
  output logic                   dst_full,
  output logic                   busy,
  output logic                   err
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));
  localparam int SW = CNT_W + $clog2(NUM_REL + 1) + 1;

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt, nxt;
  logic [NUM_REGS-1:0]            under;
  logic [SW-1:0]                  up, dn;
  logic                           trk;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_busy[i] = cnt[`ID_SB_SLICE(src_addr, i, AW)] != '0;
    assign src_one[i]  = cnt[`ID_SB_SLICE(src_addr, i, AW)] == CNT_W'(1);
  end

  assign dst_full = cnt[dst_addr] == MAX;
  assign busy     = |cnt;

  // Issue and any number of releases net out; more releases than writers clamps to zero.
  always_comb begin
    nxt   = cnt;
    under = '0;
    up    = '0;
    dn    = '0;
    trk   = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      trk = (FILE == RF_FP) || (r != 0);
      up  = SW'(cnt[r]) + SW'(trk && inc && dst_addr == AW'(r));
      dn  = '0;
      for (int j = 0; j < NUM_REL; j++)
        dn = dn + SW'(trk && rel_hit[j] && `ID_SB_SLICE(rel_addr, j, AW) == AW'(r));
      under[r] = dn > up;
      nxt[r]   = under[r] ? '0 : CNT_W'(up - dn);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= nxt;
      err <= err | (|under);
    end
  end
endmodule

// File: rtl/id_scoreboard_stage.sv
// Decode/issue stage with per-register pending-writer scoreboards (int + FP) and ID->EX registers.
// Optional ID_SB_BYPASS_EN: a same-cycle writing release clears a single-writer RAW and forwards rel_data.
module id_scoreboard_stage
  import id_sb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_SRC  = 3,
  parameter int NUM_REL  = 2,
  parameter int CNT_W    = 2,
  parameter int AW       = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [XLEN-1:0]          id_pc,
  input  logic [XLEN-1:0]          id_inst,
  input  logic [NUM_SRC-1:0]       id_src_use,
  input  logic [NUM_SRC-1:0]       id_src_fp,
  input  logic [NUM_SRC*AW-1:0]    id_src_addr,
  input  logic [NUM_SRC*XLEN-1:0]  id_src_data,
  input  logic                     id_dst_wen,
  input  logic                     id_dst_fp,
  input  logic [AW-1:0]            id_dst_addr,
  input  logic                     ex_stall,
  input  logic                     mem_flush,
  input  logic [NUM_REL-1:0]       rel_valid,
  input  logic [NUM_REL-1:0]       rel_fp,
  input  logic [NUM_REL-1:0]       rel_wen,
  input  logic [NUM_REL*AW-1:0]    rel_addr,
  input  logic [NUM_REL*XLEN-1:0]  rel_data,
  output logic                     id_stall,
  output logic                     id_issue,
  output logic                     ex_valid,
  output logic [XLEN-1:0]          ex_pc,
  output logic [XLEN-1:0]          ex_inst,
  output logic [NUM_SRC*XLEN-1:0]  ex_src_data,
  output logic                     ex_dst_wen,
  output logic                     ex_dst_fp,
  output logic [AW-1:0]            ex_dst_addr,
  output logic                     sb_busy,
  output logic                     sb_err,
  output logic [31:0]              raw_stall_cnt,
  output logic [31:0]              waw_stall_cnt
);
  logic [NUM_SRC-1:0]      int_busy, fp_busy, int_one, fp_one, src_raw, src_byp;
  logic [NUM_REL-1:0]      int_rel, fp_rel;
  logic                    int_full, fp_full, int_any, fp_any, int_err, fp_err;
  logic                    raw, full, inc_int, inc_fp;
  logic [NUM_SRC*XLEN-1:0] src_data;

  // x0 releases are dropped so they cannot flag an underflow on an untracked register.
  for (genvar j = 0; j < NUM_REL; j++) begin : g_rel
    assign int_rel[j] = rel_valid[j] & ~rel_fp[j] & (`ID_SB_SLICE(rel_addr, j, AW) != '0);
    assign fp_rel[j]  = rel_valid[j] &  rel_fp[j];
  end

  always_comb begin
    src_byp  = '0;
    src_data = id_src_data;
`ifdef ID_SB_BYPASS_EN
    for (int i = 0; i < NUM_SRC; i++)
      for (int j = NUM_REL - 1; j >= 0; j--)
        if (id_src_use[i] && (id_src_fp[i] ? fp_one[i] : int_one[i]) && rel_valid[j] && rel_wen[j]
            && rel_fp[j] == id_src_fp[i]
            && `ID_SB_SLICE(rel_addr, j, AW) == `ID_SB_SLICE(id_src_addr, i, AW)) begin
          src_byp[i] = 1'b1;
          `ID_SB_SLICE(src_data, i, XLEN) = `ID_SB_SLICE(rel_data, j, XLEN);
        end
`endif
  end

`ifndef ID_SB_BYPASS_EN
  logic unused_rel;
  assign unused_rel = ^{rel_wen, rel_data, int_one, fp_one};
`endif

  assign src_raw  = id_src_use & ((id_src_fp & fp_busy) | (~id_src_fp & int_busy)) & ~src_byp;
  assign raw      = |src_raw;
  assign full     = id_dst_wen & (id_dst_fp ? fp_full : int_full);
  assign id_stall = (id_valid & (raw | full)) | ex_stall;
  assign id_issue = id_valid & ~id_stall & ~mem_flush;
  assign inc_int  = id_issue & id_dst_wen & ~id_dst_fp;
  assign inc_fp   = id_issue & id_dst_wen &  id_dst_fp;
  assign sb_busy  = int_any | fp_any;
  assign sb_err   = int_err | fp_err;

  sb_table #(.NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .NUM_REL(NUM_REL), .CNT_W(CNT_W), .AW(AW),
             .FILE(RF_INT)) u_int (
    .clk(clk), .rst(rst), .src_addr(id_src_addr), .dst_addr(id_dst_addr), .inc(inc_int),
    .rel_hit(int_rel), .rel_addr(rel_addr), .src_busy(int_busy), .src_one(int_one),
    .dst_full(int_full), .busy(int_any), .err(int_err));

  sb_table #(.NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .NUM_REL(NUM_REL), .CNT_W(CNT_W), .AW(AW),
             .FILE(RF_FP)) u_fp (
    .clk(clk), .rst(rst), .src_addr(id_src_addr), .dst_addr(id_dst_addr), .inc(inc_fp),
    .rel_hit(fp_rel), .rel_addr(rel_addr), .src_busy(fp_busy), .src_one(fp_one),
    .dst_full(fp_full), .busy(fp_any), .err(fp_err));

  // Flush beats the EX hold so a squashed slot drains as a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_inst     <= XLEN'(NOP);
      ex_src_data <= '0;
      ex_dst_wen  <= 1'b0;
      ex_dst_fp   <= 1'b0;
      ex_dst_addr <= '0;
    end else if (id_issue) begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_inst     <= id_inst;
      ex_src_data <= src_data;
      ex_dst_wen  <= id_dst_wen;
      ex_dst_fp   <= id_dst_fp;
      ex_dst_addr <= id_dst_addr;
    end else if (!ex_stall || mem_flush) begin
      ex_valid <= 1'b0;
      ex_inst  <= XLEN'(NOP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_stall_cnt <= '0;
      waw_stall_cnt <= '0;
    end else begin
      if (id_valid && raw && raw_stall_cnt != '1)
        raw_stall_cnt <= raw_stall_cnt + 32'd1;
      if (id_valid && full && !raw && waw_stall_cnt != '1)
        waw_stall_cnt <= waw_stall_cnt + 32'd1;
    end
  end
endmodule
